// File: rtl/rs422_test_if.sv
// RS-422 link tester: sends a programmable byte as 8N1 frames on five outputs and
// counts received/mismatched frames on nine inputs, all controlled over the OPB bus.
module rs422_test_if #(
   parameter int CLK_DIV = 868
) (
   input  logic        OPB_CLK,
   input  logic        OPB_RST,
   input  logic [31:0] OPB_DI,
   output logic [31:0] OPB_DO,
   input  logic [31:0] OPB_ADDR,
   input  logic        RS422_WE,
   input  logic        RS422_RE,
   input  logic        SYNC_LOC_MONITOR,
   input  logic        SYNC_MONITOR,
   input  logic        DMD_MSSB_RX,
   input  logic        ENCODER_RX1,
   input  logic        ENCODER_RX2,
   input  logic        BMPLS,
   input  logic        PRI_QUADR_A,
   input  logic        PRI_QUADR_B,
   input  logic        PRI_QUADR_I,
   output logic        SYNC_LOC_OUT,
   output logic        SYNC_OUT,
   output logic        DMD_MSSB_TX,
   output logic        ENCODER_TX1,
   output logic        ENCODER_TX2
);
   localparam int HALF = CLK_DIV / 2;
   localparam int CW   = $clog2(CLK_DIV);
   localparam int NCH  = 9;

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic [4:0]  addr;
   logic        ctl_wr, ctl_start, ctl_stop, ctl_clear;
   logic [7:0]  test_pattern;
   logic [31:0] tx_trans_bytes;
   logic [31:0] rdata;
   logic        unused_addr;

   tx_state_t   tx_state;
   logic        tx_line, tx_busy, run, tx_done, stop_req, tx_forever, tx_last;
   logic [CW-1:0] tx_baud;
   logic [3:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic [31:0] tx_left;

   logic [NCH-1:0] rx_in, rx_prev, rx_done, rx_bad;
   logic [1:0]     rx_sync  [NCH];
   rx_state_t      rx_state [NCH];
   logic [CW-1:0]  rx_baud  [NCH];
   logic [2:0]     rx_bit   [NCH];
   logic [7:0]     rx_data  [NCH];
   logic [31:0]    recv_cnt [NCH];
   logic [31:0]    err_cnt  [NCH];
   logic [NCH-1:0] recv_flag, err_flag;

   assign addr        = OPB_ADDR[4:0];
   assign unused_addr = ^OPB_ADDR[31:5];
   assign ctl_wr      = RS422_WE && (addr == 5'h02);
   assign ctl_start   = ctl_wr && OPB_DI[0];
   assign ctl_stop    = ctl_wr && OPB_DI[1];
   assign ctl_clear   = ctl_wr && OPB_DI[2];
   assign tx_last     = !tx_forever && (tx_left == 32'd1);

   assign rx_in = {PRI_QUADR_I, PRI_QUADR_B, PRI_QUADR_A, BMPLS, ENCODER_RX2,
                   ENCODER_RX1, DMD_MSSB_RX, SYNC_MONITOR, SYNC_LOC_MONITOR};

   assign SYNC_LOC_OUT = tx_line;
   assign SYNC_OUT     = tx_line;
   assign DMD_MSSB_TX  = tx_line;
   assign ENCODER_TX1  = tx_line;
   assign ENCODER_TX2  = tx_line;

   always_ff @(posedge OPB_CLK or negedge OPB_RST) begin
      if (!OPB_RST) begin
         test_pattern   <= '0;
         tx_trans_bytes <= '0;
      end else if (RS422_WE) begin
         if (addr == 5'h00) test_pattern <= OPB_DI[7:0];
         if (addr == 5'h01) tx_trans_bytes <= OPB_DI;
      end
   end

   // Transmitter and test control. The next line level is registered one bit ahead,
   // so the start bit leaves on the very edge that accepts START.
   always_ff @(posedge OPB_CLK or negedge OPB_RST) begin
      if (!OPB_RST) begin
         tx_state   <= TX_IDLE;
         tx_line    <= 1'b1;
         tx_busy    <= 1'b0;
         run        <= 1'b0;
         tx_done    <= 1'b0;
         stop_req   <= 1'b0;
         tx_forever <= 1'b0;
         tx_baud    <= '0;
         tx_bit     <= '0;
         tx_shift   <= '0;
         tx_left    <= '0;
      end else if (ctl_clear) begin
         tx_state <= TX_IDLE;
         tx_line  <= 1'b1;
         tx_busy  <= 1'b0;
         run      <= 1'b0;
         tx_done  <= 1'b0;
         stop_req <= 1'b0;
      end else begin
         if (ctl_stop) begin
            run <= 1'b0;
            if (tx_busy) stop_req <= 1'b1;
         end else if (ctl_start && !tx_busy) begin
            run        <= 1'b1;
            tx_done    <= 1'b0;
            tx_busy    <= 1'b1;
            stop_req   <= 1'b0;
            tx_state   <= TX_SEND;
            tx_left    <= tx_trans_bytes;
            tx_forever <= (tx_trans_bytes == 32'd0);
            tx_shift   <= test_pattern;
            tx_bit     <= '0;
            tx_baud    <= '0;
            tx_line    <= 1'b0;
         end
         if (tx_state == TX_SEND) begin
            if (tx_baud == CW'(CLK_DIV - 1)) begin
               tx_baud <= '0;
               if (tx_bit == 4'd9) begin
                  if (!tx_forever) tx_left <= tx_left - 32'd1;
                  if (stop_req || ctl_stop || tx_last) begin
                     tx_state <= TX_IDLE;
                     tx_busy  <= 1'b0;
                     tx_line  <= 1'b1;
                     stop_req <= 1'b0;
                     if (tx_last) tx_done <= 1'b1;
                  end else begin
                     tx_bit   <= '0;
                     tx_line  <= 1'b0;
                     tx_shift <= test_pattern;
                  end
               end else begin
                  tx_bit  <= tx_bit + 4'd1;
                  tx_line <= (tx_bit == 4'd8) ? 1'b1 : tx_shift[tx_bit[2:0]];
               end
            end else begin
               tx_baud <= tx_baud + CW'(1);
            end
         end
      end
   end

   // Per-channel receivers; they always track frames and emit a one-cycle done/bad pulse.
   always_ff @(posedge OPB_CLK or negedge OPB_RST) begin
      if (!OPB_RST) begin
         rx_prev <= '1;
         rx_done <= '0;
         rx_bad  <= '0;
         for (int i = 0; i < NCH; i++) begin
            rx_sync[i]  <= 2'b11;
            rx_state[i] <= RX_IDLE;
            rx_baud[i]  <= '0;
            rx_bit[i]   <= '0;
            rx_data[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            rx_sync[i] <= {rx_sync[i][0], rx_in[i]};
            rx_prev[i] <= rx_sync[i][1];
            rx_done[i] <= 1'b0;
            rx_bad[i]  <= 1'b0;
            if (ctl_clear) begin
               rx_state[i] <= RX_IDLE;
            end else begin
               case (rx_state[i])
                  RX_IDLE: begin
                     if (rx_prev[i] && !rx_sync[i][1]) begin
                        rx_state[i] <= RX_START;
                        rx_baud[i]  <= '0;
                     end
                  end
                  RX_START: begin
                     if (rx_baud[i] == CW'(HALF - 1)) begin
                        rx_baud[i]  <= '0;
                        rx_bit[i]   <= '0;
                        rx_state[i] <= rx_sync[i][1] ? RX_IDLE : RX_DATA;
                     end else begin
                        rx_baud[i] <= rx_baud[i] + CW'(1);
                     end
                  end
                  RX_DATA: begin
                     if (rx_baud[i] == CW'(CLK_DIV - 1)) begin
                        rx_baud[i] <= '0;
                        rx_data[i] <= {rx_sync[i][1], rx_data[i][7:1]};
                        rx_bit[i]  <= rx_bit[i] + 3'd1;
                        if (rx_bit[i] == 3'd7) rx_state[i] <= RX_STOP;
                     end else begin
                        rx_baud[i] <= rx_baud[i] + CW'(1);
                     end
                  end
                  default: begin
                     if (rx_baud[i] == CW'(CLK_DIV - 1)) begin
                        rx_baud[i]  <= '0;
                        rx_state[i] <= RX_IDLE;
                        rx_done[i]  <= 1'b1;
                        rx_bad[i]   <= (rx_data[i] != test_pattern) || !rx_sync[i][1];
                     end else begin
                        rx_baud[i] <= rx_baud[i] + CW'(1);
                     end
                  end
               endcase
            end
         end
      end
   end

   // Saturating statistics; only frames finishing while a test runs are counted.
   always_ff @(posedge OPB_CLK or negedge OPB_RST) begin
      if (!OPB_RST) begin
         recv_flag <= '0;
         err_flag  <= '0;
         for (int i = 0; i < NCH; i++) begin
            recv_cnt[i] <= '0;
            err_cnt[i]  <= '0;
         end
      end else if (ctl_clear) begin
         recv_flag <= '0;
         err_flag  <= '0;
         for (int i = 0; i < NCH; i++) begin
            recv_cnt[i] <= '0;
            err_cnt[i]  <= '0;
         end
      end else if (run) begin
         for (int i = 0; i < NCH; i++) begin
            if (rx_done[i]) begin
               recv_flag[i] <= 1'b1;
               if (recv_cnt[i] != '1) recv_cnt[i] <= recv_cnt[i] + 32'd1;
               if (rx_bad[i]) begin
                  err_flag[i] <= 1'b1;
                  if (err_cnt[i] != '1) err_cnt[i] <= err_cnt[i] + 32'd1;
               end
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         5'h00:   rdata = {24'h0, test_pattern};
         5'h01:   rdata = tx_trans_bytes;
         5'h02:   rdata = {29'h0, tx_done, run, tx_busy};
         5'h03:   rdata = {7'h0, err_flag, 7'h0, recv_flag};
         default: begin
            for (int i = 0; i < NCH; i++) begin
               if (addr == 5'(i + 4))  rdata = recv_cnt[i];
               if (addr == 5'(i + 13)) rdata = err_cnt[i];
            end
         end
      endcase
   end

   always_ff @(posedge OPB_CLK or negedge OPB_RST) begin
      if (!OPB_RST) OPB_DO <= '0;
      else if (RS422_RE) OPB_DO <= rdata;
   end
endmodule

// File: tb/tb_rs422_test_if.sv
// Self-checking bench for rs422_test_if with a short bit period and a frame-level model.
module tb_rs422_test_if;
   localparam int CLK_DIV = 16;
   localparam int HALF    = CLK_DIV / 2;
   localparam int FRAME   = 10 * CLK_DIV;

   logic        OPB_CLK = 1'b0;
   logic        OPB_RST;
   logic [31:0] OPB_DI, OPB_DO, OPB_ADDR;
   logic        RS422_WE, RS422_RE;
   logic [8:0]  rx_lines;
   logic        SYNC_LOC_OUT, SYNC_OUT, DMD_MSSB_TX, ENCODER_TX1, ENCODER_TX2;
   logic [4:0]  tx_all;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] data;
      logic       start_ok;
      logic       stop;
      logic       all_eq;
   } tx_frame_t;
   tx_frame_t txq[$];

   logic [31:0] exp_recv [9];
   logic [31:0] exp_err  [9];
   logic [8:0]  exp_rflag, exp_eflag;
   logic        model_run;
   logic [7:0]  model_pattern;

   rs422_test_if #(.CLK_DIV(CLK_DIV)) dut (
      .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .OPB_DI(OPB_DI), .OPB_DO(OPB_DO),
      .OPB_ADDR(OPB_ADDR), .RS422_WE(RS422_WE), .RS422_RE(RS422_RE),
      .SYNC_LOC_MONITOR(rx_lines[0]), .SYNC_MONITOR(rx_lines[1]), .DMD_MSSB_RX(rx_lines[2]),
      .ENCODER_RX1(rx_lines[3]), .ENCODER_RX2(rx_lines[4]), .BMPLS(rx_lines[5]),
      .PRI_QUADR_A(rx_lines[6]), .PRI_QUADR_B(rx_lines[7]), .PRI_QUADR_I(rx_lines[8]),
      .SYNC_LOC_OUT(SYNC_LOC_OUT), .SYNC_OUT(SYNC_OUT), .DMD_MSSB_TX(DMD_MSSB_TX),
      .ENCODER_TX1(ENCODER_TX1), .ENCODER_TX2(ENCODER_TX2)
   );

   assign tx_all = {SYNC_LOC_OUT, SYNC_OUT, DMD_MSSB_TX, ENCODER_TX1, ENCODER_TX2};

   always #5 OPB_CLK = ~OPB_CLK;

   // Decodes every frame appearing on the TX outputs into txq.
   initial begin
      tx_frame_t fr;
      forever begin
         @(posedge OPB_CLK); #1;
         if (OPB_RST === 1'b1 && SYNC_LOC_OUT === 1'b0) begin
            fr.all_eq = (tx_all == 5'h00);
            repeat (HALF) @(posedge OPB_CLK); #1;
            fr.start_ok = (tx_all == 5'h00);
            for (int b = 0; b < 8; b++) begin
               repeat (CLK_DIV) @(posedge OPB_CLK); #1;
               fr.data[b] = SYNC_LOC_OUT;
               if (tx_all != 5'h00 && tx_all != 5'h1F) fr.all_eq = 1'b0;
            end
            repeat (CLK_DIV) @(posedge OPB_CLK); #1;
            fr.stop = SYNC_LOC_OUT;
            if (tx_all != 5'h00 && tx_all != 5'h1F) fr.all_eq = 1'b0;
            txq.push_back(fr);
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge OPB_CLK);
      OPB_ADDR = a; OPB_DI = d; RS422_WE = 1'b1;
      @(negedge OPB_CLK);
      RS422_WE = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge OPB_CLK);
      OPB_ADDR = a; RS422_RE = 1'b1;
      @(negedge OPB_CLK);
      RS422_RE = 1'b0;
      d = OPB_DO;
   endtask

   task automatic model_clear();
      for (int c = 0; c < 9; c++) begin
         exp_recv[c] = '0;
         exp_err[c]  = '0;
      end
      exp_rflag = '0;
      exp_eflag = '0;
      model_run = 1'b0;
   endtask

   // Drives one 8N1 frame on an RX channel and books it in the reference model.
   task automatic send_frame(input int ch, input logic [7:0] d, input logic stopb);
      logic [9:0] bits;
      bits = {stopb, d, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx_lines[ch] = bits[k];
         repeat (CLK_DIV) @(negedge OPB_CLK);
      end
      rx_lines[ch] = 1'b1;
      repeat (2 * CLK_DIV) @(negedge OPB_CLK);
      if (model_run) begin
         exp_recv[ch]  = exp_recv[ch] + 1;
         exp_rflag[ch] = 1'b1;
         if (d != model_pattern || !stopb) begin
            exp_err[ch]   = exp_err[ch] + 1;
            exp_eflag[ch] = 1'b1;
         end
      end
   endtask

   task automatic send_glitch(input int ch);
      rx_lines[ch] = 1'b0;
      repeat (HALF / 2) @(negedge OPB_CLK);
      rx_lines[ch] = 1'b1;
      repeat (2 * CLK_DIV) @(negedge OPB_CLK);
   endtask

   task automatic begin_run(input logic [7:0] pat);
      bus_write(32'h02, 32'h4);
      model_clear();
      bus_write(32'h00, {24'h0, pat});
      bus_write(32'h01, 32'd1);
      bus_write(32'h02, 32'h1);
      model_run = 1'b1;
      model_pattern = pat;
      repeat (FRAME + 2 * CLK_DIV) @(negedge OPB_CLK);
      txq.delete();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      OPB_RST = 1'b0;
      repeat (3) @(negedge OPB_CLK);
      n_vec++;
      if (OPB_DO !== 32'h0) begin n_err++; $display("[TB] FAIL reset_do: got %h want 0", OPB_DO); end
      n_vec++;
      if (tx_all !== 5'h1F) begin n_err++; $display("[TB] FAIL reset_tx: got %b want 11111", tx_all); end
      OPB_RST = 1'b1;
      model_clear();
      model_pattern = 8'h00;
      for (int a = 0; a < 5; a++) begin
         bus_read(a, d);
         n_vec++;
         if (d !== 32'h0) begin n_err++; $display("[TB] FAIL reset_reg%0d: got %h want 0", a, d); end
      end
   endtask

   task automatic test_registers();
      logic [31:0] d, r;
      bus_write(32'h00, 32'hA5);
      bus_read(32'h00, d);
      n_vec++;
      if (d !== 32'hA5) begin n_err++; $display("[TB] FAIL pattern_rw: got %h want 000000a5", d); end
      bus_write(32'h01, 32'h10);
      bus_read(32'h01, d);
      n_vec++;
      if (d !== 32'h10) begin n_err++; $display("[TB] FAIL trans_rw: got %h want 00000010", d); end
      for (int k = 0; k < 3; k++) begin
         r = $urandom;
         bus_write(32'h00, r);
         bus_read(32'h20, d);
         n_vec++;
         if (d !== {24'h0, r[7:0]}) begin n_err++; $display("[TB] FAIL pattern_alias: got %h want %h", d, {24'h0, r[7:0]}); end
         r = $urandom;
         bus_write(32'h01, r);
         bus_read(32'h01, d);
         n_vec++;
         if (d !== r) begin n_err++; $display("[TB] FAIL trans_rand: got %h want %h", d, r); end
      end
      bus_write(32'h1F, $urandom);
      bus_read(32'h1F, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("[TB] FAIL unmapped_1f: got %h want 0", d); end
      bus_read(32'h16, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("[TB] FAIL unmapped_16: got %h want 0", d); end
   endtask

   task automatic test_tx();
      logic [31:0] d;
      logic [7:0]  pat;
      int          cnt, lat, wc;
      for (int r = 0; r < 2; r++) begin
         pat = (r == 0) ? 8'h55 : 8'($urandom);
         cnt = (r == 0) ? 5 : $urandom_range(1, 3);
         bus_write(32'h00, {24'h0, pat});
         bus_write(32'h01, cnt);
         model_pattern = pat;
         txq.delete();
         bus_write(32'h02, 32'h1);
         model_run = 1'b1;
         lat = 0;
         while (SYNC_LOC_OUT && lat < 3) begin @(posedge OPB_CLK); #1; lat++; end
         n_vec++;
         if (lat > 2) begin n_err++; $display("[TB] FAIL tx_latency: got %0d clocks want <=2", lat); end
         wc = 0;
         while (txq.size() < cnt && wc < (cnt + 1) * FRAME) begin @(posedge OPB_CLK); wc++; end
         repeat (3 * FRAME) @(negedge OPB_CLK);
         n_vec++;
         if (txq.size() != cnt) begin n_err++; $display("[TB] FAIL tx_count: got %0d frames want %0d", txq.size(), cnt); end
         foreach (txq[i]) begin
            n_vec++;
            if ({txq[i].start_ok, txq[i].all_eq, txq[i].stop, txq[i].data} !== {3'b111, pat}) begin
               n_err++;
               $display("[TB] FAIL tx_frame%0d: got start=%b eq=%b stop=%b data=%h want 1 1 1 %h",
                        i, txq[i].start_ok, txq[i].all_eq, txq[i].stop, txq[i].data, pat);
            end
         end
         bus_read(32'h02, d);
         n_vec++;
         if (d !== 32'h6) begin n_err++; $display("[TB] FAIL tx_ctrl_done: got %h want 00000006", d); end
      end
   endtask

   task automatic test_rx_match();
      logic [31:0] d;
      begin_run(8'h55);
      for (int ch = 0; ch < 3; ch++)
         for (int k = 0; k < 5; k++) send_frame(ch, 8'h55, 1'b1);
      for (int c = 0; c < 9; c++) begin
         bus_read(4 + c, d);
         n_vec++;
         if (d !== exp_recv[c]) begin n_err++; $display("[TB] FAIL match_recv%0d: got %h want %h", c + 1, d, exp_recv[c]); end
         bus_read(13 + c, d);
         n_vec++;
         if (d !== exp_err[c]) begin n_err++; $display("[TB] FAIL match_err%0d: got %h want %h", c + 1, d, exp_err[c]); end
      end
      bus_read(32'h03, d);
      n_vec++;
      if (d !== 32'h7) begin n_err++; $display("[TB] FAIL match_status: got %h want 00000007", d); end
   endtask

   task automatic test_rx_error();
      logic [31:0] d;
      begin_run(8'hAA);
      for (int k = 0; k < 3; k++) send_frame(0, 8'h55, 1'b1);
      for (int k = 0; k < 3; k++) send_frame(1, 8'hAA, 1'b1);
      send_frame(0, 8'hAA, 1'b0);
      send_glitch(0);
      send_glitch(2);
      for (int c = 0; c < 9; c++) begin
         bus_read(4 + c, d);
         n_vec++;
         if (d !== exp_recv[c]) begin n_err++; $display("[TB] FAIL error_recv%0d: got %h want %h", c + 1, d, exp_recv[c]); end
         bus_read(13 + c, d);
         n_vec++;
         if (d !== exp_err[c]) begin n_err++; $display("[TB] FAIL error_err%0d: got %h want %h", c + 1, d, exp_err[c]); end
      end
      bus_read(32'h03, d);
      n_vec++;
      if (d !== {7'h0, exp_eflag, 7'h0, exp_rflag}) begin
         n_err++; $display("[TB] FAIL error_status: got %h want %h", d, {7'h0, exp_eflag, 7'h0, exp_rflag});
      end
   endtask

   task automatic test_rx_random();
      logic [31:0] d;
      logic [7:0]  pat;
      int          ch;
      pat = 8'($urandom);
      begin_run(pat);
      for (int k = 0; k < 24; k++) begin
         ch = $urandom_range(0, 8);
         send_frame(ch, ($urandom_range(0, 1) == 1) ? pat : 8'($urandom), $urandom_range(0, 4) != 0);
      end
      bus_write(32'h02, 32'h2);
      model_run = 1'b0;
      for (int k = 0; k < 3; k++) send_frame($urandom_range(0, 8), 8'($urandom), 1'b1);
      for (int c = 0; c < 9; c++) begin
         bus_read(4 + c, d);
         n_vec++;
         if (d !== exp_recv[c]) begin n_err++; $display("[TB] FAIL rand_recv%0d: got %h want %h", c + 1, d, exp_recv[c]); end
         bus_read(13 + c, d);
         n_vec++;
         if (d !== exp_err[c]) begin n_err++; $display("[TB] FAIL rand_err%0d: got %h want %h", c + 1, d, exp_err[c]); end
      end
      bus_read(32'h03, d);
      n_vec++;
      if (d !== {7'h0, exp_eflag, 7'h0, exp_rflag}) begin
         n_err++; $display("[TB] FAIL rand_status: got %h want %h", d, {7'h0, exp_eflag, 7'h0, exp_rflag});
      end
   endtask

   task automatic test_stop_clear();
      logic [31:0] d;
      int          wc;
      bus_write(32'h01, 32'd0);
      txq.delete();
      bus_write(32'h02, 32'h1);
      repeat (FRAME + FRAME / 2) @(negedge OPB_CLK);
      bus_write(32'h02, 32'h2);
      wc = 0;
      while (txq.size() < 2 && wc < 2 * FRAME) begin @(posedge OPB_CLK); wc++; end
      repeat (3 * FRAME) @(negedge OPB_CLK);
      n_vec++;
      if (txq.size() != 2) begin n_err++; $display("[TB] FAIL stop_frames: got %0d want 2", txq.size()); end
      foreach (txq[i]) begin
         n_vec++;
         if ({txq[i].start_ok, txq[i].all_eq, txq[i].stop, txq[i].data} !== {3'b111, model_pattern}) begin
            n_err++; $display("[TB] FAIL stop_frame%0d: got data=%h stop=%b want %h 1", i, txq[i].data, txq[i].stop, model_pattern);
         end
      end
      bus_read(32'h02, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("[TB] FAIL stop_ctrl: got %h want 0", d); end
      bus_write(32'h02, 32'h1);
      repeat (5 * CLK_DIV + 3) @(negedge OPB_CLK);
      bus_write(32'h02, 32'h4);
      model_clear();
      n_vec++;
      if (tx_all !== 5'h1F) begin n_err++; $display("[TB] FAIL clear_tx_now: got %b want 11111", tx_all); end
      repeat (2 * FRAME) @(negedge OPB_CLK);
      n_vec++;
      if (tx_all !== 5'h1F) begin n_err++; $display("[TB] FAIL clear_tx_idle: got %b want 11111", tx_all); end
      bus_read(32'h00, d);
      n_vec++;
      if (d !== {24'h0, model_pattern}) begin n_err++; $display("[TB] FAIL clear_pattern: got %h want %h", d, model_pattern); end
      bus_read(32'h02, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("[TB] FAIL clear_ctrl: got %h want 0", d); end
      for (int c = 0; c < 9; c++) begin
         bus_read(4 + c, d);
         n_vec++;
         if (d !== exp_recv[c]) begin n_err++; $display("[TB] FAIL clear_recv%0d: got %h want %h", c + 1, d, exp_recv[c]); end
         bus_read(13 + c, d);
         n_vec++;
         if (d !== exp_err[c]) begin n_err++; $display("[TB] FAIL clear_err%0d: got %h want %h", c + 1, d, exp_err[c]); end
      end
      bus_read(32'h03, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("[TB] FAIL clear_status: got %h want 0", d); end
   endtask

   initial begin
      OPB_RST  = 1'b0;
      OPB_DI   = '0;
      OPB_ADDR = '0;
      RS422_WE = 1'b0;
      RS422_RE = 1'b0;
      rx_lines = '1;
      test_reset();
      test_registers();
      test_tx();
      test_rx_match();
      test_rx_error();
      test_rx_random();
      test_stop_clear();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
